// File: rtl/gpio_pkg.sv
// Shared constants for the OPB GPIO block with edge interrupts.
// Register addresses, default parameter values and the counter width helper.
package gpio_pkg;

   localparam logic [3:0] A_IN_RAW  = 4'd0;
   localparam logic [3:0] A_IN_DEB  = 4'd1;
   localparam logic [3:0] A_OUT     = 4'd2;
   localparam logic [3:0] A_OUT_SET = 4'd3;
   localparam logic [3:0] A_OUT_CLR = 4'd4;
   localparam logic [3:0] A_IRQ_STS = 4'd5;
   localparam logic [3:0] A_RISE_EN = 4'd6;
   localparam logic [3:0] A_FALL_EN = 4'd7;

   localparam int N_IN_DEF  = 19;
   localparam int N_OUT_DEF = 8;
   localparam int SYNC_DEF  = 2;
   localparam int DEB_DEF   = 16;

   // ceil(log2(cycles)), at least one bit
   function automatic int deb_cnt_w(input int cycles);
      int w;
      w = 0;
      for (int i = 0; i < 17; i++)
         if ((1 << w) < cycles)
            w = w + 1;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/opb_gpio_irq_if.sv
// OPB register access bundle: address, write data, strobes and read data.
// The bus master drives the strobes; the GPIO block returns registered data.
interface opb_gpio_irq_if;

   logic [31:0] OPB_ADDR;
   logic [31:0] OPB_DI;
   logic [31:0] OPB_DO;
   logic        GPIO_RE;
   logic        GPIO_WE;

   modport master (
      output OPB_ADDR, OPB_DI, GPIO_RE, GPIO_WE,
      input  OPB_DO
   );

   modport slave (
      input  OPB_ADDR, OPB_DI, GPIO_RE, GPIO_WE,
      output OPB_DO
   );

endinterface

// File: rtl/gpio_debounce.sv
// One input bit: synchroniser chain followed by a stability-window debouncer.
// deb only follows sync once they have disagreed for DEB_CYCLES clocks in a row.
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_DEF,
   parameter int DEB_CYCLES  = DEB_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic din_i,
   output logic sync_o,
   output logic deb_o
);

   localparam int CW = deb_cnt_w(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   deb_q, deb_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   sync_s;

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
      deb_d  = deb_q;
      cnt_d  = '0;
      if (sync_s != deb_q) begin
         if (cnt_q == CNT_MAX)
            deb_d = sync_s;
         else
            cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         deb_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   assign sync_o = sync_s;
   assign deb_o  = deb_q;

endmodule

// File: rtl/opb_gpio_irq.sv
// OPB-attached GPIO: debounced inputs with edge interrupts, set/clear outputs.
// Status is set from the registered deb edge, so a set beats a same-cycle W1C.
module opb_gpio_irq
   import gpio_pkg::*;
#(
   parameter int N_IN        = N_IN_DEF,
   parameter int N_OUT       = N_OUT_DEF,
   parameter int SYNC_STAGES = SYNC_DEF,
   parameter int DEB_CYCLES  = DEB_DEF
) (
   input  logic             OPB_CLK,
   input  logic             OPB_RST,
   opb_gpio_irq_if.slave    bus,
   input  logic [N_IN-1:0]  GPIO_IN,
   output logic [N_OUT-1:0] GPIO_OUT,
   output logic             GPIO_IRQ
);

   logic [N_IN-1:0]  sync, deb;
   logic [N_IN-1:0]  deb_prev_q;
   logic [N_IN-1:0]  sts_q, sts_d;
   logic [N_IN-1:0]  ren_q, ren_d;
   logic [N_IN-1:0]  fen_q, fen_d;
   logic [N_IN-1:0]  w1c, set_ev;
   logic [N_OUT-1:0] out_q, out_d;
   logic [31:0]      do_q, do_d, rdata;
   logic             irq_q;
   logic [3:0]       addr;
   logic             unused_bits;

   assign addr        = bus.OPB_ADDR[3:0];
   assign unused_bits = ^{bus.OPB_ADDR[31:4], bus.OPB_DI};

   for (genvar i = 0; i < N_IN; i++) begin : g_in
      gpio_debounce #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_CYCLES  (DEB_CYCLES)
      ) u_deb (
         .clk_i  (OPB_CLK),
         .rst_i  (OPB_RST),
         .din_i  (GPIO_IN[i]),
         .sync_o (sync[i]),
         .deb_o  (deb[i])
      );
   end

   always_comb begin
      rdata = '0;
      case (addr)
         A_IN_RAW:  rdata[N_IN-1:0]  = sync;
         A_IN_DEB:  rdata[N_IN-1:0]  = deb;
         A_OUT:     rdata[N_OUT-1:0] = out_q;
         A_IRQ_STS: rdata[N_IN-1:0]  = sts_q;
         A_RISE_EN: rdata[N_IN-1:0]  = ren_q;
         A_FALL_EN: rdata[N_IN-1:0]  = fen_q;
         default:   rdata = '0;
      endcase
      do_d = bus.GPIO_RE ? rdata : '0;
   end

   always_comb begin
      out_d = out_q;
      ren_d = ren_q;
      fen_d = fen_q;
      w1c   = '0;
      if (bus.GPIO_WE) begin
         case (addr)
            A_OUT:     out_d = bus.OPB_DI[N_OUT-1:0];
            A_OUT_SET: out_d = out_q | bus.OPB_DI[N_OUT-1:0];
            A_OUT_CLR: out_d = out_q & ~bus.OPB_DI[N_OUT-1:0];
            A_IRQ_STS: w1c   = bus.OPB_DI[N_IN-1:0];
            A_RISE_EN: ren_d = bus.OPB_DI[N_IN-1:0];
            A_FALL_EN: fen_d = bus.OPB_DI[N_IN-1:0];
            default:   ;
         endcase
      end
      set_ev = (deb & ~deb_prev_q & ren_q) | (~deb & deb_prev_q & fen_q);
      sts_d  = (sts_q & ~w1c) | set_ev;
   end

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         deb_prev_q <= '0;
         sts_q      <= '0;
         ren_q      <= '0;
         fen_q      <= '0;
         out_q      <= '0;
         do_q       <= '0;
         irq_q      <= 1'b0;
      end else begin
         deb_prev_q <= deb;
         sts_q      <= sts_d;
         ren_q      <= ren_d;
         fen_q      <= fen_d;
         out_q      <= out_d;
         do_q       <= do_d;
         irq_q      <= |sts_q;
      end
   end

   assign bus.OPB_DO = do_q;
   assign GPIO_OUT   = out_q;
   assign GPIO_IRQ   = irq_q;

endmodule

// File: tb/tb_opb_gpio_irq.sv
// Bench for opb_gpio_irq: directed scenarios then random traffic,
// each cycle compared against a behavioural model of the register block.
module tb_opb_gpio_irq;

   localparam int NI = 19;
   localparam int NO = 8;
   localparam int SS = 2;
   localparam int DC = 4;
   localparam logic [31:0] MI = 32'h0007_FFFF;
   localparam logic [31:0] MO = 32'h0000_00FF;

   logic          clk = 1'b0;
   logic          rst;
   logic [NI-1:0] gin;
   logic [NO-1:0] gout;
   logic          girq;
   int            total = 0;
   int            bad = 0;

   opb_gpio_irq_if bus ();

   always #5 clk = ~clk;

   opb_gpio_irq #(
      .N_IN        (NI),
      .N_OUT       (NO),
      .SYNC_STAGES (SS),
      .DEB_CYCLES  (DC)
   ) dut (
      .OPB_CLK  (clk),
      .OPB_RST  (rst),
      .bus      (bus),
      .GPIO_IN  (gin),
      .GPIO_OUT (gout),
      .GPIO_IRQ (girq)
   );

   // reference state
   logic [31:0] m_pipe [SS];
   logic [31:0] hist [$];
   logic [31:0] m_deb, m_prev, m_out, m_sts, m_ren, m_fen, m_do;
   logic        m_irq;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic model_clear();
      foreach (m_pipe[k]) m_pipe[k] = '0;
      hist.delete();
      m_deb  = '0;
      m_prev = '0;
      m_out  = '0;
      m_sts  = '0;
      m_ren  = '0;
      m_fen  = '0;
      m_do   = '0;
      m_irq  = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      model_clear();
      #1;
      chk("rst_do", bus.OPB_DO, 32'h0);
      chk("rst_out", 32'(gout), 32'h0);
      chk("rst_irq", 32'(girq), 32'h0);
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // advance one clock: model from pre-edge inputs, then compare outputs
   task automatic tick();
      logic [31:0] a, di, rd, sy, clr, set, nd;
      logic        re, we, all_diff;
      re = bus.GPIO_RE;
      we = bus.GPIO_WE;
      a  = bus.OPB_ADDR & 32'hF;
      di = bus.OPB_DI;
      sy = m_pipe[SS-1];
      case (a)
         32'd0:   rd = sy;
         32'd1:   rd = m_deb;
         32'd2:   rd = m_out;
         32'd5:   rd = m_sts;
         32'd6:   rd = m_ren;
         32'd7:   rd = m_fen;
         default: rd = '0;
      endcase
      set = ((m_deb & ~m_prev & m_ren) | (~m_deb & m_prev & m_fen)) & MI;
      clr = (we && a == 32'd5) ? (di & MI) : '0;
      // a bit flips once its synced value disagreed with deb for DC samples
      hist.push_back(sy);
      if (hist.size() > DC) void'(hist.pop_front());
      nd = m_deb;
      if (hist.size() == DC) begin
         for (int i = 0; i < NI; i++) begin
            all_diff = 1'b1;
            foreach (hist[k])
               if (hist[k][i] == m_deb[i]) all_diff = 1'b0;
            if (all_diff) nd[i] = ~m_deb[i];
         end
      end
      m_irq  = (m_sts != 0);
      m_do   = re ? rd : '0;
      m_sts  = (m_sts & ~clr) | set;
      m_prev = m_deb;
      m_deb  = nd;
      if (we) begin
         case (a)
            32'd2: m_out = di & MO;
            32'd3: m_out = (m_out | di) & MO;
            32'd4: m_out = m_out & ~di & MO;
            32'd6: m_ren = di & MI;
            32'd7: m_fen = di & MI;
            default: ;
         endcase
      end
      for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = 32'(gin);
      @(posedge clk);
      #1;
      chk("do", bus.OPB_DO, m_do);
      chk("gpio_out", 32'(gout), m_out);
      chk("gpio_irq", 32'(girq), 32'(m_irq));
      chk("deb", 32'(dut.deb), m_deb);
   endtask

   task automatic op(input logic re, input logic we, input logic [3:0] a,
                     input logic [31:0] d);
      bus.GPIO_RE  = re;
      bus.GPIO_WE  = we;
      bus.OPB_ADDR = {28'h0, a};
      bus.OPB_DI   = d;
      tick();
      bus.GPIO_RE = 1'b0;
      bus.GPIO_WE = 1'b0;
   endtask

   task automatic rdchk(input logic [3:0] a, input string tag,
                        input logic [31:0] want);
      op(1'b1, 1'b0, a, 32'h0);
      chk(tag, bus.OPB_DO, want);
   endtask

   initial begin
      int idx, kind;
      logic [3:0] ra;
      bus.GPIO_RE  = 1'b0;
      bus.GPIO_WE  = 1'b0;
      bus.OPB_ADDR = '0;
      bus.OPB_DI   = '0;
      gin = '1;

      // reset with all inputs high
      do_reset(3);
      for (int k = 0; k < 8; k++) rdchk(4'(k), "rst_reg", 32'h0);
      gin = '0;
      repeat (12) tick();

      // short pulse on bit 3 is filtered
      op(1'b0, 1'b1, 4'd6, 32'h8);
      gin[3] = 1'b1;
      repeat (3) tick();
      gin[3] = 1'b0;
      repeat (10) tick();
      chk("pulse_deb", 32'(dut.deb[3]), 32'h0);
      rdchk(4'd5, "pulse_sts", 32'h0);
      chk("pulse_irq", 32'(girq), 32'h0);

      // held high: deb at clock 6, status at 7, irq at 8
      gin[3] = 1'b1;
      repeat (5) tick();
      chk("clk5_deb", 32'(dut.deb[3]), 32'h0);
      tick();
      chk("clk6_deb", 32'(dut.deb[3]), 32'h1);
      tick();
      chk("clk7_sts", 32'(dut.sts_q), 32'h8);
      tick();
      chk("clk8_irq", 32'(girq), 32'h1);
      op(1'b0, 1'b1, 4'd5, 32'h8);
      chk("w1c_irq_c1", 32'(girq), 32'h1);
      tick();
      chk("w1c_irq_c2", 32'(girq), 32'h0);
      gin[3] = 1'b0;
      repeat (10) tick();

      // output set/clear
      op(1'b0, 1'b1, 4'd2, 32'hF0);
      op(1'b0, 1'b1, 4'd3, 32'h03);
      op(1'b0, 1'b1, 4'd4, 32'h80);
      rdchk(4'd2, "out_rd", 32'h73);
      chk("out_pin", 32'(gout), 32'h73);
      op(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF);
      rdchk(4'd2, "out_wide", 32'hFF);
      rdchk(4'd3, "rd_set", 32'h0);
      rdchk(4'd12, "rd_rsvd", 32'h0);

      // falling-edge set collides with W1C: set wins
      gin[0] = 1'b1;
      repeat (10) tick();
      op(1'b0, 1'b1, 4'd7, 32'h1);
      gin[0] = 1'b0;
      repeat (6) tick();
      chk("fall_deb", 32'(dut.deb[0]), 32'h0);
      op(1'b0, 1'b1, 4'd5, 32'h1);
      chk("set_wins", 32'(dut.sts_q[0]), 32'h1);
      rdchk(4'd5, "set_wins_rd", 32'h1);
      op(1'b0, 1'b1, 4'd5, 32'h1);

      // reset in the middle of a debounce count
      gin[5] = 1'b1;
      repeat (4) tick();
      chk("cnt_mid", 32'(dut.g_in[5].u_deb.cnt_q), 32'h2);
      do_reset(2);
      chk("rst_deb", 32'(dut.deb[5]), 32'h0);
      repeat (5) tick();
      chk("rel_deb5", 32'(dut.deb[5]), 32'h0);
      tick();
      chk("rel_deb6", 32'(dut.deb[5]), 32'h1);
      rdchk(4'd5, "rel_sts", 32'h0);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            idx = int'($urandom_range(0, NI - 1));
            gin[idx] = ~gin[idx];
         end
         if ($urandom_range(0, 299) == 0) do_reset(1);
         ra = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(5, 7))
                                          : 4'($urandom_range(0, 15));
         kind = int'($urandom_range(0, 3));
         if (kind == 1)
            op(1'b1, 1'b0, ra, 32'h0);
         else if (kind == 2)
            op(1'b0, 1'b1, ra, $urandom);
         else
            tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
